// File: rtl/seq_arb_rr_4req_hold.sv
// seq_arb_rr_4req_hold
//   Round-robin arbiter for one shared single-port resource and four
//   requesters. A grant is held until the owner signals done, the owner
//   drops its request, or HOLD_MAX cycles have elapsed (forced preemption).
//   Every grant is followed by a one-cycle bus-turnaround gap.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   req      in   [3:0] request vector, req[i] = requester i wants the bus
//   done     in   current owner finished (looked at only while BUSY)
//   state    out  [1:0] FSM state code (IDLE=0, BUSY=1, GAP=2)
//   grant    out  [3:0] one-hot grant, 0000 outside BUSY
//   owner    out  [1:0] index of the current / most recent grantee
//   preempt  out  high during a GAP caused by hold-limit expiry
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner, waiting for any request
// BUSY  | grant asserted to owner, hold counter running
// GAP   | one-cycle turnaround after a grant, grant forced to 0000
// BAD   | unused code, recovers to IDLE

module seq_arb_rr_4req_hold #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] state,
  output logic [3:0] grant,
  output logic [1:0] owner,
  output logic       preempt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  localparam logic [2:0] HOLD_LIM = 3'(HOLD_MAX);

  state_t     st;
  logic [1:0] ptr;
  logic [2:0] cnt;
  logic [1:0] win;
  logic       hold_exp;
  logic       release_now;

  // First requester found scanning ptr, ptr+1, ... with wrap-around.
  // Iterating from the farthest offset down lets the nearest one win.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    pick = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign win         = pick(req, ptr);
  assign hold_exp    = (cnt == HOLD_LIM);
  assign release_now = done || !req[owner] || hold_exp;
  assign state       = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= S_IDLE;
      grant   <= 4'b0000;
      owner   <= 2'd0;
      preempt <= 1'b0;
      ptr     <= 2'd0;
      cnt     <= 3'd0;
    end else begin
      case (st)
        S_IDLE, S_GAP: begin
          preempt <= 1'b0;
          if (|req) begin
            st    <= S_BUSY;
            grant <= 4'b0001 << win;
            owner <= win;
            cnt   <= 3'd1;
          end else begin
            st    <= S_IDLE;
            grant <= 4'b0000;
          end
        end
        S_BUSY: begin
          if (release_now) begin
            st    <= S_GAP;
            grant <= 4'b0000;
            ptr   <= owner + 2'd1;
            // done on the limit cycle is an ordinary release, not a preemption
            preempt <= hold_exp && !done && req[owner];
          end else begin
            cnt     <= cnt + 3'd1;
            preempt <= 1'b0;
          end
        end
        default: begin
          st      <= S_IDLE;
          grant   <= 4'b0000;
          preempt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arb_rr_4req_hold.sv
module tb_seq_arb_rr_4req_hold;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, req1;
  logic       done, done1;
  logic [1:0] state, state1;
  logic [3:0] grant, grant1;
  logic [1:0] owner, owner1;
  logic       preempt, preempt1;

  int total = 0;
  int bad   = 0;

  seq_arb_rr_4req_hold #(.HOLD_MAX(4)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .state(state), .grant(grant), .owner(owner), .preempt(preempt)
  );

  seq_arb_rr_4req_hold #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .done(done1),
    .state(state1), .grant(grant1), .owner(owner1), .preempt(preempt1)
  );

  always #5 clk = ~clk;

  // Reference model for the HOLD_MAX=4 instance: phase 0 idle, 1 busy, 2 gap.
  localparam int HM = 4;
  int m_phase, m_owner, m_ptr, m_held;
  bit m_pre;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_pre = 0;
  endtask

  task automatic model_tick(input logic [3:0] r, input logic d);
    if (m_phase == 1) begin
      if (d || !r[m_owner] || m_held == HM) begin
        m_pre   = (m_held == HM) && !d && r[m_owner];
        m_phase = 2;
        m_ptr   = (m_owner + 1) % 4;
      end else begin
        m_held++;
        m_pre = 0;
      end
    end else begin
      m_pre = 0;
      if (r != 4'b0000) begin
        for (int k = 3; k >= 0; k--)
          if (r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        m_phase = 1;
        m_held  = 1;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  function automatic logic [3:0] m_grant();
    return (m_phase == 1) ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  task automatic step();
    model_tick(req, done);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; req = 4'b0000; done = 1'b0; req1 = 4'b0000; done1 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b0000; done = 1'b0; req1 = 4'b0000; done1 = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      total++;
      if ({state, grant, owner, preempt} !== 9'b0) begin
        bad++;
        $display("FAIL reset_hold state=%0d grant=%b owner=%0d preempt=%b want all zero",
                 state, grant, owner, preempt);
      end
    end
    reset = 1'b1;
    repeat (3) begin
      step();
      total++;
      if ({state, grant, owner, preempt} !== 9'b0) begin
        bad++;
        $display("FAIL reset_idle state=%0d grant=%b owner=%0d preempt=%b want all zero",
                 state, grant, owner, preempt);
      end
    end
  endtask

  task automatic test_done_release();
    apply_reset();
    req = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      done = (c == 3);
      if (c == 4) req = 4'b0000;
      step();
      total++;
      if (c <= 2) begin
        if (state !== 2'd1 || grant !== 4'b0100 || owner !== 2'd2) begin
          bad++;
          $display("FAIL done_busy cyc%0d state=%0d grant=%b owner=%0d want 1/0100/2",
                   c, state, grant, owner);
        end
      end else if (c == 3) begin
        if (state !== 2'd2 || grant !== 4'b0000 || preempt !== 1'b0) begin
          bad++;
          $display("FAIL done_gap state=%0d grant=%b preempt=%b want 2/0000/0",
                   state, grant, preempt);
        end
      end else begin
        if (state !== 2'd0 || grant !== 4'b0000) begin
          bad++;
          $display("FAIL done_idle state=%0d grant=%b want 0/0000", state, grant);
        end
      end
    end
    done = 1'b0;
  endtask

  task automatic test_hold_preempt();
    logic [3:0] eg;
    apply_reset();
    req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      eg = 4'(1 << g);
      for (int c = 0; c < 4; c++) begin
        step();
        total++;
        if (state !== 2'd1 || grant !== eg || preempt !== 1'b0) begin
          bad++;
          $display("FAIL hold_busy g%0d c%0d state=%0d grant=%b preempt=%b want 1/%b/0",
                   g, c, state, grant, preempt, eg);
        end
      end
      step();
      total++;
      if (state !== 2'd2 || grant !== 4'b0000 || preempt !== 1'b1) begin
        bad++;
        $display("FAIL hold_gap g%0d state=%0d grant=%b preempt=%b want 2/0000/1",
                 g, state, grant, preempt);
      end
    end
    step();
    total++;
    if (grant !== 4'b0001 || owner !== 2'd0) begin
      bad++;
      $display("FAIL hold_wrap grant=%b owner=%0d want 0001/0", grant, owner);
    end
    req = 4'b0000;
  endtask

  task automatic test_ptr_wrap();
    apply_reset();
    req = 4'b1000;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0011;
    step();
    total++;
    if (state !== 2'd1 || grant !== 4'b0001 || owner !== 2'd0) begin
      bad++;
      $display("FAIL ptr_wrap state=%0d grant=%b owner=%0d want 1/0001/0", state, grant, owner);
    end
    req = 4'b0000;
  endtask

  task automatic test_req_drop();
    apply_reset();
    req = 4'b0010;
    step();
    step();
    req = 4'b0000;
    step();
    total++;
    if (state !== 2'd2 || grant !== 4'b0000 || preempt !== 1'b0) begin
      bad++;
      $display("FAIL drop_gap state=%0d grant=%b preempt=%b want 2/0000/0", state, grant, preempt);
    end
    step();
    total++;
    if (state !== 2'd0 || grant !== 4'b0000) begin
      bad++;
      $display("FAIL drop_idle state=%0d grant=%b want 0/0000", state, grant);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 4'b1000;
    step();
    total++;
    if (grant !== 4'b1000) begin
      bad++;
      $display("FAIL areset_pre grant=%b want 1000", grant);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (grant !== 4'b0000 || state !== 2'd0) begin
      bad++;
      $display("FAIL areset_mid grant=%b state=%0d want 0000/0", grant, state);
    end
    @(posedge clk); #3;
    reset = 1'b1;
    req = 4'b1111;
    step();
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL areset_after grant=%b want 0001", grant);
    end
    req = 4'b0000;
  endtask

  task automatic test_hold1();
    logic [3:0] eg;
    apply_reset();
    req1 = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      step();
      eg = (i % 2 == 0) ? 4'(1 << ((i / 2) % 2)) : 4'b0000;
      total++;
      if (state1 !== ((i % 2 == 0) ? 2'd1 : 2'd2) || grant1 !== eg ||
          preempt1 !== ((i % 2 == 0) ? 1'b0 : 1'b1)) begin
        bad++;
        $display("FAIL hold1 i%0d state=%0d grant=%b preempt=%b want grant %b",
                 i, state1, grant1, preempt1, eg);
      end
    end
    req1 = 4'b0000;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      req  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      done = ($urandom_range(0, 5) == 0);
      step();
      total++;
      if (state !== 2'(m_phase) || grant !== m_grant() || owner !== 2'(m_owner) ||
          preempt !== m_pre) begin
        bad++;
        $display("FAIL random i%0d got s=%0d g=%b o=%0d p=%b want s=%0d g=%b o=%0d p=%b",
                 i, state, grant, owner, preempt, m_phase, m_grant(), m_owner, m_pre);
      end
    end
    req = 4'b0000; done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_done_release();
    test_hold_preempt();
    test_ptr_wrap();
    test_req_drop();
    test_async_reset();
    test_hold1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
